ika2151_sodec: RTL and testbench
================================

IKA2151_SODEC -- requirements
Module: IKA2151_sodec

Interface
REQ-001 SHALL have parameter EXP0_ZERO, default 1: 1 = exponent 0 decodes to 0x0000; 0 = exponent 0 decodes as exponent 1.
REQ-002 SHALL have port i_EMUCLK  input  1  emulator master clock; all state changes on its rising edge.
REQ-003 SHALL have port i_MRST_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port i_phi1_NCEN_n  input  1  clock enable, active low; one "tick" = a rising edge of i_EMUCLK with i_phi1_NCEN_n low.
REQ-005 SHALL have port i_SO  input  1  serial floating-point sound data from the accumulator stage.
REQ-006 SHALL have port i_WORD_START  input  1  high on the tick carrying bit 0 of a word.
REQ-007 SHALL have port i_WORD_CH  input  1  channel of the starting word, sampled with i_WORD_START: 0 = right, 1 = left.
REQ-008 SHALL have port i_ERR_CLR  input  1  clears o_FRAME_ERR.
REQ-009 SHALL have port o_R_DATA  output  16  last decoded right sample, two's complement.
REQ-010 SHALL have port o_L_DATA  output  16  last decoded left sample, two's complement.
REQ-011 SHALL have port o_R_VALID  output  1  one-tick pulse on o_R_DATA update.
REQ-012 SHALL have port o_L_VALID  output  1  one-tick pulse on o_L_DATA update.
REQ-013 SHALL have port o_FRAME_ERR  output  1  sticky framing-error flag.

Function
REQ-014 All registers SHALL update only on ticks; non-tick edges hold state.
REQ-015 Word format, bits in order of arrival (tick 0..15): bits 0-9 = mantissa M[0..9], LSB first; M[9] = inverted sign (1 = positive); bits 10-12 = exponent E[0..2], LSB first; bits 13-15 ignored.
REQ-016 State machine: IDLE, RECV, COMMIT; 4-bit bit counter; 13-bit shift register; latched channel bit.
REQ-017 IDLE: i_WORD_START high -> capture bit 0 and channel, counter = 1, go RECV; otherwise stay.
REQ-018 RECV: capture i_SO into bit position counter, increment counter; after bit 12 is captured (counter reaches 13) go COMMIT.
REQ-019 COMMIT (tick 13 after start): register decoded value into the latched channel's data output, pulse that channel's VALID for exactly this tick, go IDLE.
REQ-020 Decode: m = {~M[9], M[8:0]} as 10-bit signed; shift s = E-1 for E = 1..7; result = sign-extended m << s, 16 bits, no overflow possible (max 0x7FC0, min 0x8000).
REQ-021 E = 0: result 0x0000 if EXP0_ZERO = 1, else as E = 1.
REQ-022 Latency: the decoded sample becomes visible after the tick 13 ticks after the i_WORD_START tick; VALID is high in the cycle window following that tick.
REQ-023 i_WORD_START in RECV: discard partial word, no VALID, set o_FRAME_ERR, restart at bit 0 with new channel (counter = 1).
REQ-024 i_WORD_START in COMMIT: commit the old word normally and simultaneously start the new word (counter = 1, RECV); no error.
REQ-025 Back-to-back 16-tick words, alternating or same channel, SHALL decode without loss.
REQ-026 The non-updated channel's data output and VALID SHALL hold/stay low.
REQ-027 i_ERR_CLR on a tick clears o_FRAME_ERR; a simultaneous set event wins (flag = 1).
REQ-028 Bits 13-15 SHALL NOT affect outputs or errors.

Reset
REQ-029 i_MRST_n low SHALL immediately force: state IDLE, counter 0, shift register 0, o_R_DATA = o_L_DATA = 0x0000, o_R_VALID = o_L_VALID = 0, o_FRAME_ERR = 0.
REQ-030 Reset mid-word SHALL discard the word; no VALID pulse results from it after release.
REQ-031 After release, the first decode SHALL require a fresh i_WORD_START.

Verification
REQ-032 Right word M = 0x3FF, E = 7 -> o_R_DATA = 0x7FC0, o_R_VALID pulse at tick 13, o_L_* unchanged.
REQ-033 Left word M = 0x000, E = 7 -> o_L_DATA = 0x8000; left word M = 0x201, E = 1 -> 0x0001; M = 0x1FF, E = 3 -> 0xFFFC.
REQ-034 M = 0x2AB, E = 0 with EXP0_ZERO = 1 -> 0x0000; with EXP0_ZERO = 0 -> 0x00AB.
REQ-035 i_WORD_START re-asserted at tick 5 of a word -> no VALID for it, o_FRAME_ERR = 1, the new word decodes correctly; i_ERR_CLR -> flag 0.
REQ-036 Continuous R/L alternating words every 16 ticks, with i_phi1_NCEN_n low only every 2nd clock -> every word decoded, one VALID per word, no error.
REQ-037 i_MRST_n pulsed low at tick 8 of a word -> all outputs 0 immediately, no VALID after release until the next full word.

Source files
------------

// File: rtl/ika2151_sodec.sv
// Serial floating-point sample decoder: deserialises 13-bit mantissa/exponent words
// from the accumulator stream and expands them to 16-bit two's-complement samples.
module ika2151_sodec #(
  parameter int EXP0_ZERO = 1
) (
  input  logic        i_EMUCLK,
  input  logic        i_MRST_n,
  input  logic        i_phi1_NCEN_n,
  input  logic        i_SO,
  input  logic        i_WORD_START,
  input  logic        i_WORD_CH,
  input  logic        i_ERR_CLR,
  output logic [15:0] o_R_DATA,
  output logic [15:0] o_L_DATA,
  output logic        o_R_VALID,
  output logic        o_L_VALID,
  output logic        o_FRAME_ERR
);

  localparam int DATA_W = 16;

  typedef enum logic [1:0] {IDLE, RECV, COMMIT} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic [12:0] sr, sr_nxt;
  logic        ch, ch_nxt;
  logic        err_set;
  logic        commit;
  logic        tick;
  logic signed [DATA_W-1:0] dec;

  // Mantissa sign bit arrives inverted; exponent 1..7 maps to a left shift of 0..6.
  function automatic logic signed [DATA_W-1:0] decode(input logic [12:0] w);
    logic signed [9:0]        m10;
    logic signed [DATA_W-1:0] m;
    logic [2:0]               e;
    m10 = {~w[9], w[8:0]};
    m   = m10;
    e   = w[12:10];
    if (e == 3'd0) begin
      return (EXP0_ZERO != 0) ? '0 : m;
    end
    return m <<< (e - 3'd1);
  endfunction

  assign tick = ~i_phi1_NCEN_n;
  assign dec  = decode(sr);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    sr_nxt    = sr;
    ch_nxt    = ch;
    err_set   = 1'b0;
    commit    = 1'b0;
    case (state)
      IDLE: begin
        if (i_WORD_START) begin
          sr_nxt    = {12'd0, i_SO};
          ch_nxt    = i_WORD_CH;
          cnt_nxt   = 4'd1;
          state_nxt = RECV;
        end
      end
      RECV: begin
        if (i_WORD_START) begin
          // A new word start inside a word means the framing slipped; drop the partial word.
          err_set   = 1'b1;
          sr_nxt    = {12'd0, i_SO};
          ch_nxt    = i_WORD_CH;
          cnt_nxt   = 4'd1;
        end else begin
          sr_nxt[cnt] = i_SO;
          cnt_nxt     = cnt + 4'd1;
          if (cnt == 4'd12) begin
            state_nxt = COMMIT;
          end
        end
      end
      COMMIT: begin
        commit    = 1'b1;
        cnt_nxt   = 4'd0;
        state_nxt = IDLE;
        if (i_WORD_START) begin
          sr_nxt    = {12'd0, i_SO};
          ch_nxt    = i_WORD_CH;
          cnt_nxt   = 4'd1;
          state_nxt = RECV;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_EMUCLK or negedge i_MRST_n) begin
    if (!i_MRST_n) begin
      state       <= IDLE;
      cnt         <= 4'd0;
      sr          <= 13'd0;
      ch          <= 1'b0;
      o_R_DATA    <= 16'h0000;
      o_L_DATA    <= 16'h0000;
      o_R_VALID   <= 1'b0;
      o_L_VALID   <= 1'b0;
      o_FRAME_ERR <= 1'b0;
    end else if (tick) begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      sr          <= sr_nxt;
      ch          <= ch_nxt;
      o_R_VALID   <= commit & ~ch;
      o_L_VALID   <= commit & ch;
      if (commit && !ch) o_R_DATA <= dec;
      if (commit && ch)  o_L_DATA <= dec;
      o_FRAME_ERR <= err_set | (o_FRAME_ERR & ~i_ERR_CLR);
    end
  end

endmodule

// File: tb/tb_ika2151_sodec.sv
// Scoreboard bench for ika2151_sodec: two instances (EXP0_ZERO = 1 and 0) share one stimulus stream.
module tb_ika2151_sodec;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b1;
  logic ncen = 1'b1, so = 1'b0, start = 1'b0, wch = 1'b0, clr = 1'b0;
  logic [15:0] r_a, l_a, r_b, l_b;
  logic rv_a, lv_a, rv_b, lv_b, err_a, err_b;

  ika2151_sodec #(.EXP0_ZERO(1)) dut_a (
    .i_EMUCLK(clk), .i_MRST_n(rst_n), .i_phi1_NCEN_n(ncen), .i_SO(so),
    .i_WORD_START(start), .i_WORD_CH(wch), .i_ERR_CLR(clr),
    .o_R_DATA(r_a), .o_L_DATA(l_a), .o_R_VALID(rv_a), .o_L_VALID(lv_a), .o_FRAME_ERR(err_a)
  );

  ika2151_sodec #(.EXP0_ZERO(0)) dut_b (
    .i_EMUCLK(clk), .i_MRST_n(rst_n), .i_phi1_NCEN_n(ncen), .i_SO(so),
    .i_WORD_START(start), .i_WORD_CH(wch), .i_ERR_CLR(clr),
    .o_R_DATA(r_b), .o_L_DATA(l_b), .o_R_VALID(rv_b), .o_L_VALID(lv_b), .o_FRAME_ERR(err_b)
  );

  int checks = 0;
  int passes = 0;
  bit slow = 1'b0;
  logic [16:0] qa[$];
  logic [16:0] qb[$];
  logic [15:0] expd[2][2];
  bit pv[2][2];
  logic tick_q = 1'b0;

  always @(posedge clk) tick_q <= ~ncen;

  function automatic logic [15:0] model(input logic [9:0] m, input logic [2:0] e, input bit z);
    int v;
    int s;
    v = m[8:0];
    if (!m[9]) v = v - 512;
    if (e == 3'd0) begin
      if (z) return 16'h0000;
      s = 0;
    end else begin
      s = e - 1;
    end
    v = v * (1 << s);
    return 16'(v);
  endfunction

  task automatic mon(input int d, input logic [15:0] rd, input logic [15:0] ld,
                     input logic rv, input logic lv);
    logic [16:0] e;
    logic [15:0] got;
    logic [15:0] oth;
    logic v;
    bit have;
    for (int c = 0; c < 2; c++) begin
      v = (c == 1) ? lv : rv;
      if (v && pv[d][c]) begin
        checks++;
        if (tick_q) $display("FAIL valid_width dut%0d ch%0d: valid=1 after a further tick, required 0", d, c);
        else passes++;
      end
      if (v && !pv[d][c]) begin
        checks++;
        have = (d == 0) ? (qa.size() != 0) : (qb.size() != 0);
        if (!have) begin
          $display("FAIL unexpected_valid dut%0d ch%0d: valid=1 with no word pending, required 0", d, c);
        end else begin
          if (d == 0) e = qa.pop_front();
          else        e = qb.pop_front();
          if (e[16] !== 1'(c)) $display("FAIL valid_channel dut%0d: valid on ch%0d, required ch%0d", d, c, e[16]);
          else passes++;
          got = (c == 1) ? ld : rd;
          checks++;
          if (got !== e[15:0]) $display("FAIL data dut%0d ch%0d: got %h, required %h", d, c, got, e[15:0]);
          else passes++;
          expd[d][c] = e[15:0];
          oth = (c == 1) ? rd : ld;
          checks++;
          if (oth !== expd[d][1-c]) $display("FAIL hold dut%0d ch%0d: got %h, required %h", d, 1-c, oth, expd[d][1-c]);
          else passes++;
        end
      end
      pv[d][c] = v;
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      mon(0, r_a, l_a, rv_a, lv_a);
      mon(1, r_b, l_b, rv_b, lv_b);
    end else begin
      for (int d = 0; d < 2; d++) for (int c = 0; c < 2; c++) pv[d][c] = 1'b0;
    end
  end

  task automatic do_tick(input logic s, input logic st, input logic c, input logic cl);
    if (slow) begin
      ncen = 1'b1; start = 1'b0; clr = 1'b0;
      @(posedge clk); #1;
    end
    ncen = 1'b0; so = s; start = st; wch = c; clr = cl;
    @(posedge clk); #1;
    ncen = 1'b1; start = 1'b0; clr = 1'b0;
  endtask

  task automatic send_word(input logic c, input logic [9:0] m, input logic [2:0] e,
                           input int nbits, input bit push);
    logic [15:0] w;
    logic [2:0] junk;
    junk = 3'($urandom);
    w = {junk, e, m};
    if (push) begin
      qa.push_back({c, model(m, e, 1'b1)});
      qb.push_back({c, model(m, e, 1'b0)});
    end
    for (int i = 0; i < nbits; i++)
      do_tick(w[i], (i == 0), (i == 0) ? c : 1'($urandom), 1'b0);
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({r_a, l_a, rv_a, lv_a, err_a, r_b, l_b, rv_b, lv_b, err_b} !== '0)
      $display("FAIL reset_state: got %h %h %b%b%b, required all zero", r_a, l_a, rv_a, lv_a, err_a);
    else passes++;
    #2 rst_n = 1'b1;
    for (int i = 0; i < 20; i++) do_tick(1'($urandom), 1'b0, 1'b0, 1'b0);
    checks++;
    if ({r_a, l_a, rv_a, lv_a, err_a} !== '0) $display("FAIL idle_no_start: got %h %h, required 0", r_a, l_a);
    else passes++;
  endtask

  task automatic test_decode();
    send_word(1'b0, 10'h3FF, 3'd7, 16, 1'b1);
    checks++;
    if (r_a !== 16'h7FC0) $display("FAIL decode_max: got %h, required 7fc0", r_a);
    else passes++;
    checks++;
    if (l_a !== 16'h0000) $display("FAIL left_untouched: got %h, required 0000", l_a);
    else passes++;
    send_word(1'b1, 10'h000, 3'd7, 16, 1'b1);
    checks++;
    if (l_a !== 16'h8000) $display("FAIL decode_min: got %h, required 8000", l_a);
    else passes++;
    send_word(1'b1, 10'h201, 3'd1, 16, 1'b1);
    checks++;
    if (l_a !== 16'h0001) $display("FAIL decode_one: got %h, required 0001", l_a);
    else passes++;
    send_word(1'b1, 10'h1FF, 3'd3, 16, 1'b1);
    checks++;
    if (l_a !== 16'hFFFC) $display("FAIL decode_neg: got %h, required fffc", l_a);
    else passes++;
    checks++;
    if (r_a !== 16'h7FC0) $display("FAIL right_held: got %h, required 7fc0", r_a);
    else passes++;
  endtask

  task automatic test_exp0();
    send_word(1'b1, 10'h2AB, 3'd0, 16, 1'b1);
    checks++;
    if (l_a !== 16'h0000) $display("FAIL exp0_zero: got %h, required 0000", l_a);
    else passes++;
    checks++;
    if (l_b !== 16'h00AB) $display("FAIL exp0_as_e1: got %h, required 00ab", l_b);
    else passes++;
  endtask

  task automatic test_latency();
    logic [15:0] want;
    want = model(10'h155, 3'd5, 1'b1);
    send_word(1'b0, 10'h155, 3'd5, 13, 1'b1);
    checks++;
    if (rv_a !== 1'b0) $display("FAIL valid_early: got %b, required 0", rv_a);
    else passes++;
    do_tick(1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if ({rv_a, r_a} !== {1'b1, want}) $display("FAIL valid_tick13: got %b/%h, required 1/%h", rv_a, r_a, want);
    else passes++;
    do_tick(1'b0, 1'b0, 1'b0, 1'b0);
    do_tick(1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if ({rv_a, lv_a} !== 2'b00) $display("FAIL valid_one_tick: got %b%b, required 00", rv_a, lv_a);
    else passes++;
  endtask

  task automatic test_error();
    send_word(1'b0, 10'h3AA, 3'd6, 5, 1'b0);
    send_word(1'b1, 10'h0C3, 3'd4, 16, 1'b1);
    checks++;
    if ({err_a, err_b} !== 2'b11) $display("FAIL frame_err_set: got %b%b, required 11", err_a, err_b);
    else passes++;
    do_tick(1'b0, 1'b0, 1'b0, 1'b1);
    checks++;
    if ({err_a, err_b} !== 2'b00) $display("FAIL frame_err_clr: got %b%b, required 00", err_a, err_b);
    else passes++;
  endtask

  task automatic test_back_to_back();
    send_word(1'b0, 10'h2F0, 3'd2, 13, 1'b1);
    send_word(1'b1, 10'h10F, 3'd6, 16, 1'b1);
    for (int i = 0; i < 3; i++)
      send_word(1'b1, 10'($urandom), 3'($urandom), 16, 1'b1);
    checks++;
    if (err_a !== 1'b0) $display("FAIL overlap_no_err: got %b, required 0", err_a);
    else passes++;
  endtask

  task automatic test_alternating();
    slow = 1'b1;
    for (int i = 0; i < 8; i++)
      send_word(1'(i % 2), 10'($urandom), 3'($urandom), 16, 1'b1);
    slow = 1'b0;
    do_tick(1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (err_a !== 1'b0 || qa.size() != 0 || qb.size() != 0)
      $display("FAIL alt_all_decoded: err=%b pending=%0d, required err=0 pending=0", err_a, qa.size());
    else passes++;
  endtask

  task automatic test_midword_reset();
    send_word(1'b1, 10'h123, 3'd6, 8, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({r_a, l_a, rv_a, lv_a, err_a, r_b, l_b, rv_b, lv_b, err_b} !== '0)
      $display("FAIL reset_immediate: got %h %h %b%b%b, required all zero", r_a, l_a, rv_a, lv_a, err_a);
    else passes++;
    for (int d = 0; d < 2; d++) for (int c = 0; c < 2; c++) expd[d][c] = 16'h0000;
    @(posedge clk); #3 rst_n = 1'b1;
    for (int i = 0; i < 20; i++) do_tick(1'($urandom), 1'b0, 1'($urandom), 1'b0);
    checks++;
    if ({r_a, l_a, r_b, l_b} !== '0) $display("FAIL reset_discard: got %h %h, required 0000 0000", r_a, l_a);
    else passes++;
    send_word(1'b0, 10'h3C1, 3'd4, 16, 1'b1);
    do_tick(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    for (int d = 0; d < 2; d++) for (int c = 0; c < 2; c++) expd[d][c] = 16'h0000;
    test_reset();
    test_decode();
    test_exp0();
    test_latency();
    test_error();
    test_back_to_back();
    test_alternating();
    test_midword_reset();
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (qa.size() != 0 || qb.size() != 0)
      $display("FAIL words_pending: got %0d/%0d outstanding, required 0", qa.size(), qb.size());
    else passes++;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
